// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Brief    : Shared UART definitions: FSM states, line levels, bit-period
//             derivation. Also imported by the receive side.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Frame phases of the serialiser
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Line levels for the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clocks per bit period (integer divide)
    function automatic int clk_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_baud_tick
//  Brief    : Bit-period timer. Counts 0..CLK_PER_BIT-1 and wraps while
//             enabled; synchronous clear restarts it at 0. tick_o is high on
//             the last count of each bit period.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_baud_tick #(
    parameter int CLK_PER_BIT = 8,
    parameter int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running modulo counter with synchronous restart
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = (cnt_q == CNT_MAX);

endmodule : uart_tx_baud_tick
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : UART transmitter. valid/ready word input with a one-entry
//             holding buffer, serialised as start / DATA_BITS LSB-first /
//             stop. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int CLK_RATE  = 8,
    parameter int BAUD_RATE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 outgoing_data,
    output logic                 busy,
    output logic                 tx_done
);

    import uart_tx_pkg::*;

    localparam int CLK_PER_BIT = clk_per_bit(CLK_RATE, BAUD_RATE);
    localparam int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int IDX_W       = $clog2(DATA_BITS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    // Count value one cycle before the stop bit ends; used to register tx_done
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'((CLK_PER_BIT >= 2) ? CLK_PER_BIT - 2 : 0);

    generate
        if (CLK_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx: CLK_RATE/BAUD_RATE must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_tx: DATA_BITS must be 5..9");
        end
    endgenerate

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 load;
    logic                 tick;
    logic [CNT_W-1:0]     bit_cnt;

    // Timer restarts on every frame start so START always lasts a full period
    uart_tx_baud_tick #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (load),
        .en_i   (state_q != ST_IDLE),
        .cnt_o  (bit_cnt),
        .tick_o (tick)
    );

    // State, buffer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
            line_q     <= STOP_BIT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic: frame sequencing, buffer unload/refill, output levels
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        line_d     = line_q;
        busy_d     = busy_q;
        load       = 1'b0;
        done_d     = (state_q == ST_STOP) && (bit_cnt == CNT_PRE_LAST);

        case (state_q)
            ST_IDLE: begin
                line_d = STOP_BIT;
                busy_d = 1'b0;
                if (buf_full_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        line_d  = STOP_BIT;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                        line_d  = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        line_d  = STOP_BIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moving the buffered word into the shift register opens a new frame
        if (load) begin
            state_d    = ST_START;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            line_d     = START_BIT;
            busy_d     = 1'b1;
        end

        // ready is low whenever the buffer is full, so load and accept never coincide
        if (data_valid && ready_q) begin
            buf_d      = data;
            buf_full_d = 1'b1;
        end

        ready_d = !buf_full_d;
    end

    assign ready         = ready_q;
    assign outgoing_data = line_q;
    assign busy          = busy_q;
    assign tx_done       = done_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Brief    : Self-checking bench for uart_tx (DATA_BITS=8, CLK_PER_BIT=8).
//             Frame-level reference model plus a behavioural line receiver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int CPB   = 8;
    localparam int FRAME = (DB + 2) * CPB;

    logic          clk;
    logic          reset;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          ready;
    logic          outgoing_data;
    logic          busy;
    logic          tx_done;

    int n_tests = 0;
    int n_fails = 0;
    int cyc     = 0;

    uart_tx #(
        .DATA_BITS (DB),
        .CLK_RATE  (8),
        .BAUD_RATE (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data          (data),
        .data_valid    (data_valid),
        .ready         (ready),
        .outgoing_data (outgoing_data),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is FRAME cycles long; position t within it selects the level.
    bit          m_active;
    int          m_t;
    logic [DB-1:0] m_word;
    bit          m_held;
    logic [DB-1:0] m_held_word;

    function automatic logic frame_level(input logic [DB-1:0] w, input int t);
        int k;
        k = t / CPB;
        if (k == 0)  return 1'b0;
        if (k <= DB) return w[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_held   <= 1'b0;
        end else begin
            if (m_active) begin
                if (m_t == FRAME - 1) begin
                    if (m_held) begin
                        m_word <= m_held_word;
                        m_t    <= 0;
                        m_held <= 1'b0;
                    end else begin
                        m_active <= 1'b0;
                    end
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (m_held) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_word   <= m_held_word;
                m_held   <= 1'b0;
            end
            if (data_valid && !m_held) begin
                m_held      <= 1'b1;
                m_held_word <= data;
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        check("line",    outgoing_data, m_active ? frame_level(m_word, m_t) : 1'b1);
        check("busy",    busy,          m_active);
        check("ready",   ready,         !m_held);
        check("tx_done", tx_done,       m_active && (m_t == FRAME - 1));
    end

    // ---------------- behavioural line receiver ----------------
    bit          rx_on;
    int          rx_t;
    logic [DB-1:0] rx_sh;
    int          rx_ferr = 0;
    logic [DB-1:0] rx_q[$];

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            rx_on <= 1'b0;
            rx_t  <= 0;
        end else if (!rx_on) begin
            if (outgoing_data == 1'b0) begin
                rx_on <= 1'b1;
                rx_t  <= 1;
                rx_sh <= '0;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB >= 1 && rx_t / CPB <= DB) begin
                    rx_sh[rx_t / CPB - 1] <= outgoing_data;
                end else if (rx_t / CPB == DB + 1) begin
                    rx_on <= 1'b0;
                    if (outgoing_data) rx_q.push_back(rx_sh);
                    else               rx_ferr <= rx_ferr + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic lvl [0:400];

    task automatic send(input logic [DB-1:0] w, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        data       = w;
        data_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (ready === 1'b1) begin
                @(posedge clk); #1;
                acc = cyc;
                ok  = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        data_valid = 1'b0;
        data       = DB'($urandom);
        check("send_accept", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (!busy && ready) ok = 1'b1;
        end
        check("idle_timeout", ok, 1);
    endtask

    // Track pulses and busy-fall relative to the first accept cycle
    task automatic measure(input int acc, input int nfr, input string nm);
        int nd, first_d, last_d, fall;
        nd = 0; first_d = -1; last_d = -1; fall = -1;
        for (int i = 0; i < 400 && fall < 0; i++) begin
            @(posedge clk); #1;
            if (cyc - acc >= 0 && cyc - acc <= 400) lvl[cyc - acc] = outgoing_data;
            if (tx_done) begin
                nd++;
                if (first_d < 0) first_d = cyc - acc;
                last_d = cyc - acc;
            end
            if (!busy) fall = cyc - acc;
        end
        check({nm, "_done_pulses"}, nd, nfr);
        check({nm, "_first_done"}, first_d, FRAME);
        check({nm, "_last_done"}, last_d, FRAME * nfr);
        check({nm, "_busy_fall"}, fall, FRAME * nfr + 1);
    endtask

    task automatic expect_rx(input string nm, input logic [DB-1:0] exp);
        check({nm, "_avail"}, rx_q.size() > 0, 1);
        if (rx_q.size() > 0) check(nm, rx_q.pop_front(), exp);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int a, b;
        logic [9:0] exp_lv;
        logic       act;

        reset      = 1'b0;
        data       = '0;
        data_valid = 1'b0;

        // 1: long reset, then idle
        repeat (32) @(posedge clk);
        #1;
        check("rst_line", outgoing_data, 1);
        check("rst_ready", ready, 1);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        // 2: single 0xA5 frame, exact level timing
        send(8'hA5, a);
        measure(a, 1, "a5");
        exp_lv = 10'b1_10100101_0;
        for (int k = 0; k < 10; k++) begin
            act = exp_lv[k];
            for (int j = 0; j < CPB; j++) begin
                if (lvl[1 + k * CPB + j] !== exp_lv[k]) act = lvl[1 + k * CPB + j];
            end
            check($sformatf("a5_bit%0d", k), act, exp_lv[k]);
        end
        wait_idle();
        expect_rx("rx_a5", 8'hA5);

        // 3: back-to-back 0x00 then 0xFF
        send(8'h00, a);
        send(8'hFF, b);
        check("q2_accept_lat", b - a, 2);
        check("q2_ready_low", ready, 0);
        measure(a, 2, "b2b");
        wait_idle();
        expect_rx("rx_00", 8'h00);
        expect_rx("rx_ff", 8'hFF);

        // 4: valid while buffer full is ignored
        send(8'h12, a);
        send(8'h34, b);
        data       = 8'h3C;
        data_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        data_valid = 1'b0;
        wait_idle();
        check("ign_rx_count", rx_q.size(), 2);
        expect_rx("rx_12", 8'h12);
        expect_rx("rx_34", 8'h34);

        // 5: reset at clk 37 of a frame with a word buffered
        send(8'h11, a);
        send(8'h22, b);
        while (cyc < a + 37) begin
            @(posedge clk); #1;
        end
        #1;
        reset = 1'b0;
        #1;
        check("arst_line", outgoing_data, 1);
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 1);
        check("arst_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("arst_dropped", rx_q.size(), 0);
        send(8'h5A, a);
        measure(a, 1, "post_rst");
        wait_idle();
        expect_rx("rx_5a", 8'h5A);

        // 6: three-word stream decoded by the receiver
        send(8'h3C, a);
        send(8'hC3, b);
        measure(a, 2, "lb");
        send(8'h81, a);
        wait_idle();
        expect_rx("rx_3c", 8'h3C);
        expect_rx("rx_c3", 8'hC3);
        expect_rx("rx_81", 8'h81);
        check("rx_framing", rx_ferr, 0);
        check("rx_leftover", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
